// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multi-cycle CPU datapath that shares one register file,
//   one ALU, one unified memory port and the PC across several cycles per
//   instruction. Supported instructions: lw, sw, R-type (add/sub/and/or/slt),
//   beq, addi and j. Every memory state waits on the mem_ready handshake.
//
//   Optional feature macro: INSTR_COUNT_EN
//     defined   -> adds output instr_count[31:0], a wrapping count of
//                  completed instructions (illegal-op aborts are not counted).
//     undefined -> no port, no counter logic.
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int OPC_W   = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clock_enable,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_ctrl,
  output logic               illegal_op,
  output logic [3:0]         state
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]        instr_count
`endif
);

  // State encodings (fixed, visible on the debug port)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] dec_state;
  logic       illegal_raw;
  logic       funct_ok;
  logic [3:0] alu_fn;
  logic       strobe_en;
  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  assign state = state_q;

  // Strobes are live only when the FSM is running and not being reset.
  assign strobe_en = clock_enable & ~reset;

  // While reset is held, the output decode shows FETCH values regardless of
  // where the FSM was interrupted, so no partial write can escape.
  assign dec_state = reset ? S_FETCH : state_q;

  // R-type funct decode into an ALU operation plus a legality flag
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    funct_ok = 1'b1;
    alu_fn   = ALU_ADD;
    case (funct)
      FN_ADD:  alu_fn = ALU_ADD;
      FN_SUB:  alu_fn = ALU_SUB;
      FN_AND:  alu_fn = ALU_AND;
      FN_OR:   alu_fn = ALU_OR;
      FN_SLT:  alu_fn = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // Next-state logic; illegal_raw flags an abort back to FETCH
  always_comb begin
    state_d     = state_q;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC: begin
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          state_d     = S_FETCH;
          illegal_raw = 1'b1;
        end
      end
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default: begin
        // Encodings 12-15 are unreachable in normal operation; recover.
        state_d     = S_FETCH;
        illegal_raw = 1'b1;
      end
    endcase
  end

  // Datapath control decode from the (reset-overridden) registered state
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_ADD;
    case (dec_state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src   = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        i_or_d       = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        i_or_d        = 1'b1;
      end
      S_EXEC: begin
        alu_src  = 1'b1;
        alu_ctrl = alu_fn;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_BRANCH: begin
        alu_src      = 1'b1;
        alu_ctrl     = ALU_SUB;
        pc_src       = 2'b01;
        pc_write_raw = zero;
      end
      S_ADDIEX: begin
        alu_src   = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_JUMP: begin
        pc_src       = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Gate all strobes so a frozen or resetting FSM never touches state
  assign pc_write   = pc_write_raw  & strobe_en;
  assign ir_write   = ir_write_raw  & strobe_en;
  assign mem_read   = mem_read_raw  & strobe_en;
  assign mem_write  = mem_write_raw & strobe_en;
  assign reg_write  = reg_write_raw & strobe_en;
  assign illegal_op = illegal_raw   & strobe_en;

  // State register: synchronous reset, holds while clock_enable is low
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_FETCH;
    end else if (clock_enable) begin
      state_q <= state_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic completing;

  // An instruction completes when a final state hands control back to FETCH
  always_comb begin
    completing = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: completing = 1'b1;
        default: completing = 1'b0;
      endcase
    end
  end

  // Completed-instruction counter; wraps naturally at 32 bits
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_count <= 32'd0;
    end else if (clock_enable && completing) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Table-driven bench: each row is one clock cycle of inputs plus the
//   expected state and control outputs for that cycle. Rows are pushed to a
//   scoreboard queue when driven and popped/compared mid-cycle.
//   Define INSTR_COUNT_EN to also exercise the instruction counter.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [3:0] S_F = 4'd0,  S_D = 4'd1,  S_MA = 4'd2,  S_MR = 4'd3;
  localparam logic [3:0] S_MB = 4'd4, S_MW = 4'd5, S_EX = 4'd6,  S_AW = 4'd7;
  localparam logic [3:0] S_BR = 4'd8, S_IE = 4'd9, S_IW = 4'd10, S_JP = 4'd11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_BAD = 6'b111111;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111;

  // Strobe group {pc_write, ir_write, mem_read, mem_write, reg_write, illegal_op}
  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_FET  = 6'b111000;
  localparam logic [5:0] ST_MRD  = 6'b001000;
  localparam logic [5:0] ST_MWR  = 6'b000100;
  localparam logic [5:0] ST_RW   = 6'b000010;
  localparam logic [5:0] ST_ILL  = 6'b000001;
  localparam logic [5:0] ST_PW   = 6'b100000;

  typedef struct {
    logic       rst;
    logic       ce;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [5:0] strb;
    logic [3:0] alu;
    logic [1:0] pcs;
  } row_t;

  logic       clock = 1'b0;
  logic       reset, clock_enable, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl, state;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  row_t tbl[$];
  row_t exp_q[$];

  multicycle_controller #(.OPC_W(6), .FUNCT_W(6)) dut (
    .clock(clock), .reset(reset), .clock_enable(clock_enable),
    .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal_op(illegal_op),
    .state(state)
`ifdef INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
    $fatal(1);
  end

  // Datapath mux settings per state: {i_or_d, alu_src, alu_src_b, mem_to_reg, reg_dst}
  function automatic logic [5:0] mux_exp(input logic [3:0] s);
    case (s)
      S_F:     return 6'b00_01_00;
      S_D:     return 6'b00_11_00;
      S_MA:    return 6'b01_10_00;
      S_MR:    return 6'b10_00_00;
      S_MB:    return 6'b00_00_10;
      S_MW:    return 6'b10_00_00;
      S_EX:    return 6'b01_00_00;
      S_AW:    return 6'b00_00_01;
      S_BR:    return 6'b01_00_00;
      S_IE:    return 6'b01_10_00;
      default: return 6'b00_00_00;
    endcase
  endfunction

  function automatic row_t mk(input logic rst, input logic ce, input logic [5:0] op,
                              input logic [5:0] fn, input logic z, input logic rdy,
                              input logic [3:0] st, input logic [5:0] strb,
                              input logic [3:0] alu, input logic [1:0] pcs);
    row_t r;
    r.rst = rst; r.ce = ce; r.op = op; r.fn = fn; r.z = z; r.rdy = rdy;
    r.st = st; r.strb = strb; r.alu = alu; r.pcs = pcs;
    return r;
  endfunction

  // Normal running cycle shorthand
  function automatic row_t rn(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input logic rdy, input logic [3:0] st, input logic [5:0] strb,
                              input logic [3:0] alu, input logic [1:0] pcs);
    return mk(1'b0, 1'b1, op, fn, z, rdy, st, strb, alu, pcs);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare mid-cycle
  task automatic step(input row_t r, input string name);
    row_t e;
    logic [21:0] act, req;
    @(posedge clock);
    #1;
    reset = r.rst; clock_enable = r.ce; opcode = r.op; funct = r.fn;
    zero = r.z; mem_ready = r.rdy;
    exp_q.push_back(r);
    @(negedge clock);
    e = exp_q.pop_front();
    act = {state, pc_write, ir_write, mem_read, mem_write, reg_write, illegal_op,
           alu_ctrl, pc_src, i_or_d, alu_src, alu_src_b, mem_to_reg, reg_dst};
    req = {e.st, e.strb, e.alu, e.pcs, mux_exp(e.rst ? S_F : e.st)};
    check(name, {10'd0, act}, {10'd0, req});
  endtask

  initial begin
    logic [5:0] fns[4];
    logic [3:0] alus[4];
    fns  = '{FN_ADD, FN_AND, FN_OR, FN_SLT};
    alus = '{A_ADD, A_AND, A_OR, A_SLT};

    // R-type SUB from reset
    tbl.push_back(mk(1, 1, OP_R, FN_SUB, 0, 1, S_F, ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_R, FN_SUB, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_R, FN_SUB, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_R, FN_SUB, 0, 1, S_EX, ST_NONE, A_SUB, 2'b00));
    tbl.push_back(rn(OP_R, FN_SUB, 0, 1, S_AW, ST_RW,   A_ADD, 2'b00));
    // lw: one FETCH wait, MEMRD held 4 cycles
    tbl.push_back(rn(OP_LW, 6'd0, 0, 0, S_F,  ST_MRD,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_LW, 6'd0, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_LW, 6'd0, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_LW, 6'd0, 0, 1, S_MA, ST_NONE, A_ADD, 2'b00));
    for (int i = 0; i < 3; i++)
      tbl.push_back(rn(OP_LW, 6'd0, 0, 0, S_MR, ST_MRD, A_ADD, 2'b00));
    tbl.push_back(rn(OP_LW, 6'd0, 0, 1, S_MR, ST_MRD,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_LW, 6'd0, 0, 1, S_MB, ST_RW,   A_ADD, 2'b00));
    // beq taken then not taken
    tbl.push_back(rn(OP_BEQ, 6'd0, 1, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_BEQ, 6'd0, 1, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_BEQ, 6'd0, 1, 1, S_BR, ST_PW,   A_SUB, 2'b01));
    tbl.push_back(rn(OP_BEQ, 6'd0, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_BEQ, 6'd0, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_BEQ, 6'd0, 0, 1, S_BR, ST_NONE, A_SUB, 2'b01));
    // illegal opcode
    tbl.push_back(rn(OP_BAD, 6'd0, 0, 1, S_F, ST_FET, A_ADD, 2'b00));
    tbl.push_back(rn(OP_BAD, 6'd0, 0, 1, S_D, ST_ILL, A_ADD, 2'b00));
    // sw with clock_enable dropped in MEMWR
    tbl.push_back(rn(OP_SW, 6'd0, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_SW, 6'd0, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_SW, 6'd0, 0, 1, S_MA, ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_SW, 6'd0, 0, 0, S_MW, ST_MWR,  A_ADD, 2'b00));
    tbl.push_back(mk(0, 0, OP_SW, 6'd0, 0, 1, S_MW, ST_NONE, A_ADD, 2'b00));
    tbl.push_back(mk(0, 0, OP_SW, 6'd0, 0, 1, S_MW, ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_SW, 6'd0, 0, 1, S_MW, ST_MWR,  A_ADD, 2'b00));
    // frozen in FETCH while memory is ready
    tbl.push_back(mk(0, 0, OP_ADDI, 6'd0, 0, 1, S_F, ST_NONE, A_ADD, 2'b00));
    // addi
    tbl.push_back(rn(OP_ADDI, 6'd0, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_ADDI, 6'd0, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_ADDI, 6'd0, 0, 0, S_IE, ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_ADDI, 6'd0, 0, 0, S_IW, ST_RW,   A_ADD, 2'b00));
    // jump
    tbl.push_back(rn(OP_J, 6'd0, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_J, 6'd0, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_J, 6'd0, 0, 1, S_JP, ST_PW,   A_ADD, 2'b10));
    // R-type with unknown funct aborts in EXEC
    tbl.push_back(rn(OP_R, FN_BAD, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_R, FN_BAD, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_R, FN_BAD, 0, 1, S_EX, ST_ILL,  A_ADD, 2'b00));
    // remaining R-type functions
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(rn(OP_R, fns[i], 0, 1, S_F,  ST_FET,  A_ADD,   2'b00));
      tbl.push_back(rn(OP_R, fns[i], 0, 1, S_D,  ST_NONE, A_ADD,   2'b00));
      tbl.push_back(rn(OP_R, fns[i], 0, 1, S_EX, ST_NONE, alus[i], 2'b00));
      tbl.push_back(rn(OP_R, fns[i], 0, 1, S_AW, ST_RW,   A_ADD,   2'b00));
    end
    // lw aborted by reset in MEMADR
    tbl.push_back(rn(OP_LW, 6'd0, 0, 1, S_F, ST_FET,  A_ADD, 2'b00));
    tbl.push_back(rn(OP_LW, 6'd0, 0, 1, S_D, ST_NONE, A_ADD, 2'b00));
    tbl.push_back(mk(1, 1, OP_LW, 6'd0, 0, 1, S_MA, ST_NONE, A_ADD, 2'b00));
    tbl.push_back(rn(OP_LW, 6'd0, 0, 0, S_F, ST_MRD,  A_ADD, 2'b00));

    // Reset prelude
    reset = 1'b1; clock_enable = 1'b1; opcode = OP_R; funct = FN_ADD;
    zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clock);

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

`ifdef INSTR_COUNT_EN
    // Three completed instructions plus one illegal abort, then reset
    step(mk(1, 1, OP_R, FN_ADD, 0, 1, S_F, ST_NONE, A_ADD, 2'b00), "cnt_rst0");
    step(rn(OP_R, FN_ADD, 0, 1, S_F, ST_FET, A_ADD, 2'b00), "cnt_f0");
    check("cnt_zero", instr_count, 32'd0);
    step(rn(OP_R, FN_ADD, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00), "cnt_d0");
    step(rn(OP_R, FN_ADD, 0, 1, S_EX, ST_NONE, A_ADD, 2'b00), "cnt_ex");
    step(rn(OP_R, FN_ADD, 0, 1, S_AW, ST_RW,   A_ADD, 2'b00), "cnt_aw");
    step(rn(OP_BEQ, 6'd0, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00), "cnt_f1");
    check("cnt_one", instr_count, 32'd1);
    step(rn(OP_BEQ, 6'd0, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00), "cnt_d1");
    step(rn(OP_BEQ, 6'd0, 0, 1, S_BR, ST_NONE, A_SUB, 2'b01), "cnt_br");
    step(rn(OP_J, 6'd0, 0, 1, S_F,  ST_FET,  A_ADD, 2'b00), "cnt_f2");
    step(rn(OP_J, 6'd0, 0, 1, S_D,  ST_NONE, A_ADD, 2'b00), "cnt_d2");
    step(rn(OP_J, 6'd0, 0, 1, S_JP, ST_PW,   A_ADD, 2'b10), "cnt_jp");
    step(rn(OP_BAD, 6'd0, 0, 1, S_F, ST_FET, A_ADD, 2'b00), "cnt_f3");
    step(rn(OP_BAD, 6'd0, 0, 1, S_D, ST_ILL, A_ADD, 2'b00), "cnt_d3");
    step(rn(OP_BAD, 6'd0, 0, 0, S_F, ST_MRD, A_ADD, 2'b00), "cnt_f4");
    check("cnt_three", instr_count, 32'd3);
    step(mk(1, 1, OP_R, FN_ADD, 0, 0, S_F, ST_NONE, A_ADD, 2'b00), "cnt_rst1");
    step(rn(OP_R, FN_ADD, 0, 0, S_F, ST_MRD, A_ADD, 2'b00), "cnt_f5");
    check("cnt_cleared", instr_count, 32'd0);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
